// File: rtl/counter_seq_ctrl.sv
// Command-driven START/PAUSE/RESUME/STOP sequencer for a 4-bit load/enable counter.
// Optional sticky irq/irq_clr pair is built when SEQ_IRQ_EN is defined.
module counter_seq_ctrl #(
  parameter logic [3:0]  P_COUNT_MAX = 4'd10,
  parameter int unsigned P_WRAP_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [3:0]          cmd_start_val,
  input  logic [P_WRAP_W-1:0] cmd_wraps,
  output logic                cnt_load,
  output logic [3:0]          cnt_load_data,
  output logic                cnt_enable,
  input  logic [3:0]          cnt_count,
  input  logic                cnt_is_max,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [P_WRAP_W-1:0] wraps_left
`ifdef SEQ_IRQ_EN
  ,
  input  logic                irq_clr,
  output logic                irq
`endif
);

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_STOP   = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_HOLD} state_t;

  state_t r_state;
  logic   w_accept;
  logic   w_wrap;
  logic   w_last;
  logic   w_start_ok;
  logic   w_stop;
  logic   w_done_set;
  logic   w_unused;

  assign cmd_ready  = (r_state != ST_LOAD) && !rst;
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_wrap     = cnt_enable && cnt_is_max;
  assign w_last     = w_wrap && (wraps_left == P_WRAP_W'(1));
  assign w_start_ok = (cmd_wraps != '0) && (cmd_start_val <= P_COUNT_MAX);
  assign w_stop     = w_accept && (cmd_op == OP_STOP);
  // STOP on the final wrap edge suppresses done
  assign w_done_set = (r_state == ST_RUN) && w_last && !w_stop;
  // count is status only; the FSM keys off cnt_is_max
  assign w_unused   = ^cnt_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      cnt_load      <= 1'b0;
      cnt_load_data <= 4'd0;
      cnt_enable    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      wraps_left    <= '0;
    end else begin
      cnt_load <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if ((cmd_op == OP_START) && w_start_ok) begin
              r_state       <= ST_LOAD;
              cnt_load      <= 1'b1;
              cnt_load_data <= cmd_start_val;
              wraps_left    <= cmd_wraps;
              busy          <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_state    <= ST_RUN;
          cnt_enable <= 1'b1;
        end
        ST_RUN: begin
          if (w_stop) begin
            r_state    <= ST_IDLE;
            cnt_enable <= 1'b0;
            wraps_left <= '0;
            busy       <= 1'b0;
          end else begin
            if (w_wrap) wraps_left <= wraps_left - P_WRAP_W'(1);
            if (w_last) begin
              r_state    <= ST_IDLE;
              cnt_enable <= 1'b0;
              done       <= 1'b1;
              busy       <= 1'b0;
            end else if (w_accept) begin
              if (cmd_op == OP_PAUSE) begin
                r_state    <= ST_HOLD;
                cnt_enable <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (w_accept) begin
            if (cmd_op == OP_RESUME) begin
              r_state    <= ST_RUN;
              cnt_enable <= 1'b1;
            end else if (cmd_op == OP_STOP) begin
              r_state    <= ST_IDLE;
              wraps_left <= '0;
              busy       <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SEQ_IRQ_EN
  // sticky interrupt; a set on the same edge as irq_clr wins
  always_ff @(posedge clk) begin
    if (rst)             irq <= 1'b0;
    else if (w_done_set) irq <= 1'b1;
    else if (irq_clr)    irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 4-bit counter and
// load/done scoreboards; covers SEQ_IRQ_EN when that macro is defined.
module tb_counter_seq_ctrl;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_STOP   = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_start_val = 4'd0;
  logic [7:0] cmd_wraps = 8'd0;
  logic       cnt_load;
  logic [3:0] cnt_load_data;
  logic       cnt_enable;
  logic [3:0] cnt = 4'd0;
  logic       cnt_is_max;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] wraps_left;
`ifdef SEQ_IRQ_EN
  logic       irq_clr = 1'b0;
  logic       irq;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_err    = 0;
  logic [3:0] q_load[$];
  bit         q_done[$];
  logic [7:0] wl[0:63];

  counter_seq_ctrl #(.P_COUNT_MAX(4'd10), .P_WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_start_val(cmd_start_val), .cmd_wraps(cmd_wraps),
    .cnt_load(cnt_load), .cnt_load_data(cnt_load_data), .cnt_enable(cnt_enable),
    .cnt_count(cnt), .cnt_is_max(cnt_is_max), .busy(busy), .done(done),
    .err(err), .wraps_left(wraps_left)
`ifdef SEQ_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // reference counter_4bit: load over enable, wraps 10 -> 0
  always @(posedge clk) begin
    if (cnt_load)        cnt <= cnt_load_data;
    else if (cnt_enable) cnt <= (cnt == 4'd10) ? 4'd0 : cnt + 4'd1;
  end
  assign cnt_is_max = (cnt == 4'd10);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard pops when the DUT produces a load or done pulse
  always @(negedge clk) begin
    if (err) n_err++;
    if (cnt_load) begin
      if (q_load.size() == 0) check("load_unexpected", 32'(cnt_load), 32'd0);
      else check("load_data", 32'(cnt_load_data), 32'(q_load.pop_front()));
    end
    if (done) begin
      if (q_done.size() == 0) check("done_unexpected", 32'(done), 32'd0);
      else check("done_expected", 32'(done), 32'(q_done.pop_front()));
    end
  end

  task automatic send(input logic [1:0] op, input logic [3:0] v, input logic [7:0] w);
    cmd_valid = 1'b1; cmd_op = op; cmd_start_val = v; cmd_wraps = w;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_until_done(output int n_en, output bit got);
    n_en = 0; got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (cnt_enable) n_en++;
      @(negedge clk);
      if (n_en < 64) wl[n_en] = wraps_left;
      if (done) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_count(input logic [3:0] v);
    for (int c = 0; c < 50 && cnt != v; c++) @(negedge clk);
    check("wait_count", 32'(cnt), 32'(v));
  endtask

  initial begin
    int  n_en;
    bit  got;
    int  e0;
    bit  frozen;
    logic [3:0] c0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load", 32'(cnt_load), 32'd0);
    check("rst_load_data", 32'(cnt_load_data), 32'd0);
    check("rst_enable", 32'(cnt_enable), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_wraps_left", 32'(wraps_left), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1 check("ready_after_rst", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // 1: START 4 x2 -> 18 enabled edges, wraps_left steps at 7 and 18
    q_load.push_back(4'd4); q_done.push_back(1'b1);
    send(OP_START, 4'd4, 8'd2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_load_ready", 32'({cnt_load, cnt_enable, cmd_ready}), 32'b100);
    run_until_done(n_en, got);
    check("t1_done", 32'(got), 32'd1);
    check("t1_en_edges", 32'(n_en), 32'd18);
    check("t1_wl6", 32'(wl[6]), 32'd2);
    check("t1_wl7", 32'(wl[7]), 32'd1);
    check("t1_wl17", 32'(wl[17]), 32'd1);
    check("t1_wl18", 32'(wl[18]), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
`ifdef SEQ_IRQ_EN
    check("irq_set", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_held", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_cleared", 32'(irq), 32'd0);
`endif
    @(negedge clk);

    // 2: rejected STARTs
    e0 = n_err;
    send(OP_START, 4'd11, 8'd1);
    check("t2_err_val", 32'({err, busy, cnt_load}), 32'b100);
    send(OP_START, 4'd3, 8'd0);
    check("t2_err_wraps", 32'({err, busy, cnt_load}), 32'b100);
    send(OP_PAUSE, 4'd0, 8'd0);
    check("t2_err_pause_idle", 32'(err), 32'd1);
    @(negedge clk);
    check("t2_err_count", 32'(n_err - e0), 32'd3);

    // 3: PAUSE at 5 for 10 cycles, RESUME, 3 wraps complete
    q_load.push_back(4'd0); q_done.push_back(1'b1);
    send(OP_START, 4'd0, 8'd3);
    @(negedge clk);
    wait_count(4'd4);
    send(OP_PAUSE, 4'd0, 8'd0);
    check("t3_hold", 32'({busy, cnt_enable, cnt}), 32'({1'b1, 1'b0, 4'd5}));
    frozen = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (cnt != 4'd5 || cnt_enable) frozen = 1'b0;
    end
    check("t3_frozen", 32'(frozen), 32'd1);
    send(OP_RESUME, 4'd0, 8'd0);
    check("t3_resume", 32'({cnt_enable, cnt}), 32'({1'b1, 4'd5}));
    run_until_done(n_en, got);
    check("t3_done", 32'(got), 32'd1);
    check("t3_en_edges", 32'(n_en), 32'd28);
    @(negedge clk);

    // 4: STOP on final wrap edge beats done
    q_load.push_back(4'd9);
    send(OP_START, 4'd9, 8'd1);
    @(negedge clk);
    wait_count(4'd10);
    send(OP_STOP, 4'd0, 8'd0);
    check("t4_stop", 32'({busy, cnt_enable, done, wraps_left}), 32'd0);
    check("t4_wrapped", 32'(cnt), 32'd0);
    @(negedge clk);
    check("t4_no_done_pending", 32'(q_done.size()), 32'd0);
    q_load.push_back(4'd2); q_done.push_back(1'b1);
    send(OP_START, 4'd2, 8'd1);
    check("t4_restart", 32'(busy), 32'd1);
    run_until_done(n_en, got);
    check("t4_done", 32'(got), 32'd1);
    check("t4_en_edges", 32'(n_en), 32'd9);
    @(negedge clk);

    // 5: illegal commands while running
    q_load.push_back(4'd0); q_done.push_back(1'b1);
    send(OP_START, 4'd0, 8'd2);
    @(negedge clk);
    e0 = n_err;
    send(OP_START, 4'd1, 8'd1);
    check("t5_err_start", 32'({err, wraps_left}), 32'({1'b1, 8'd2}));
    send(OP_RESUME, 4'd0, 8'd0);
    check("t5_err_resume", 32'({err, wraps_left}), 32'({1'b1, 8'd2}));
    send(OP_START, 4'd5, 8'd4);
    check("t5_err_start2", 32'({err, wraps_left, busy}), 32'({1'b1, 8'd2, 1'b1}));
    @(negedge clk);
    check("t5_err_count", 32'(n_err - e0), 32'd3);
    run_until_done(n_en, got);
    check("t5_done", 32'(got), 32'd1);
    @(negedge clk);

    // 6: reset while in HOLD
    q_load.push_back(4'd1);
    send(OP_START, 4'd1, 8'd5);
    repeat (3) @(negedge clk);
    send(OP_PAUSE, 4'd0, 8'd0);
    check("t6_hold", 32'({busy, cnt_enable}), 32'b10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_outs", 32'({busy, cnt_load, cnt_enable, done, err}), 32'd0);
    check("t6_rst_data", 32'({cnt_load_data, wraps_left}), 32'd0);
    check("t6_rst_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1 check("t6_ready", 32'(cmd_ready), 32'd1);
    c0 = cnt;
    repeat (3) @(negedge clk);
    check("t6_count_kept", 32'(cnt), 32'(c0));

    check("sb_load_empty", 32'(q_load.size()), 32'd0);
    check("sb_done_empty", 32'(q_done.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
